// File: rtl/ms_pkg.sv
// ms_pkg: shared constants and types for the minesweeper neighbour-count engine
// and the reveal logic that reuses ms_nbr_cnt.
//   MS_BOARD_W   : board edge length (8)
//   MS_CELLS     : number of cells (64), cell index i = row*8 + col
//   MS_CNT_W     : natural width of a neighbour count (0..8 fits in 4 bits)
//   MS_MINE_CODE : value stored for a mined cell when MS_COUNT_MINE_FLAG_EN is defined
//   ms_state_t   : scan controller states
package ms_pkg;

    localparam int MS_BOARD_W = 8;
    localparam int MS_CELLS = 64;
    localparam int MS_CNT_W = 4;
    localparam logic [3:0] MS_MINE_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } ms_state_t;

endpackage

// File: rtl/ms_nbr_cnt.sv
// ms_nbr_cnt: purely combinational adjacent-mine counter for one cell.
// Ports:
//   mine [63:0] : mine map, bit i = cell i (i = row*8 + col)
//   idx  [5:0]  : cell whose neighbours are counted
//   cnt  [3:0]  : number of mined neighbours (0..8), border cells masked
// Neighbours that would fall off the board are masked by row/col so that the
// flat index arithmetic never wraps from one row end to the next.
module ms_nbr_cnt
    import ms_pkg::*;
(
    input  logic [MS_CELLS-1:0] mine,
    input  logic [5:0]          idx,
    output logic [MS_CNT_W-1:0] cnt
);

    logic [2:0] row;
    logic [2:0] col;
    logic       has_up;
    logic       has_dn;
    logic       has_lf;
    logic       has_rt;
    logic [7:0] nb;

    assign row    = idx[5:3];
    assign col    = idx[2:0];
    assign has_up = (row != 3'd0);
    assign has_dn = (row != 3'd7);
    assign has_lf = (col != 3'd0);
    assign has_rt = (col != 3'd7);

    // Gather the eight neighbour bits, zeroing any that lie off the board.
    always_comb begin
        nb = 8'h00;
        if (has_up && has_lf) nb[0] = mine[idx - 6'd9]; else nb[0] = 1'b0;
        if (has_up)           nb[1] = mine[idx - 6'd8]; else nb[1] = 1'b0;
        if (has_up && has_rt) nb[2] = mine[idx - 6'd7]; else nb[2] = 1'b0;
        if (has_lf)           nb[3] = mine[idx - 6'd1]; else nb[3] = 1'b0;
        if (has_rt)           nb[4] = mine[idx + 6'd1]; else nb[4] = 1'b0;
        if (has_dn && has_lf) nb[5] = mine[idx + 6'd7]; else nb[5] = 1'b0;
        if (has_dn)           nb[6] = mine[idx + 6'd8]; else nb[6] = 1'b0;
        if (has_dn && has_rt) nb[7] = mine[idx + 6'd9]; else nb[7] = 1'b0;
    end

    // Population count of the masked neighbour bits.
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, nb[i]};
        end
    end

endmodule

// File: rtl/ms_count.sv
// ms_count: neighbour-count engine. On a rising edge of gen_done it captures
// the mine map and scans the 8x8 board one cell per clock, storing each
// cell's adjacent-mine count in a register file read combinationally.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   mine[63:0] : mine map from the generator, sampled only on start
//   gen_done   : generator-complete level, rising edge starts a scan
//   rd_addr    : cell index to read
//   rd_cnt     : stored count for rd_addr (combinational)
//   rd_mine    : captured mine bit for rd_addr (combinational)
//   busy       : scan in progress
//   count_done : a completed map is held
// Build option: MS_COUNT_MINE_FLAG_EN - mined cells store all-ones instead of
// their neighbour count.
module ms_count
    import ms_pkg::*;
#(
    parameter int CNT_W = MS_CNT_W
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [MS_CELLS-1:0] mine,
    input  logic                gen_done,
    input  logic [5:0]          rd_addr,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic                rd_mine,
    output logic                busy,
    output logic                count_done
);

    ms_state_t           state;
    ms_state_t           state_nxt;
    logic                gen_done_q;
    logic                start;
    logic [MS_CELLS-1:0] mine_q;
    logic [5:0]          idx;
    logic [CNT_W-1:0]    cnt_mem [MS_CELLS];
    logic [MS_CNT_W-1:0] nbr;
    logic [CNT_W-1:0]    wr_val;

    assign start = gen_done & ~gen_done_q;

    ms_nbr_cnt u_nbr (
        .mine (mine_q),
        .idx  (idx),
        .cnt  (nbr)
    );

    // Value written to the register file for the cell under the scan pointer.
    always_comb begin
`ifdef MS_COUNT_MINE_FLAG_EN
        if (mine_q[idx]) begin
            wr_val = {CNT_W{1'b1}};
        end else begin
            wr_val = CNT_W'(nbr);
        end
`else
        wr_val = CNT_W'(nbr);
`endif
    end

    // Next-state logic; a start in any state (re)enters SCAN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_SCAN;
                else       state_nxt = ST_IDLE;
            end
            ST_SCAN: begin
                if (start)             state_nxt = ST_SCAN;
                else if (idx == 6'd63) state_nxt = ST_DONE;
                else                   state_nxt = ST_SCAN;
            end
            ST_DONE: begin
                if (start) state_nxt = ST_SCAN;
                else       state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            gen_done_q <= 1'b0;
            busy       <= 1'b0;
            count_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            gen_done_q <= gen_done;
            busy       <= (state_nxt == ST_SCAN);
            count_done <= (state_nxt == ST_DONE);
        end
    end

    // Map capture, scan pointer and register-file writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mine_q <= {MS_CELLS{1'b0}};
            idx    <= 6'd0;
            for (int i = 0; i < MS_CELLS; i++) begin
                cnt_mem[i] <= {CNT_W{1'b0}};
            end
        end else if (start) begin
            // A start mid-scan discards the partial scan and begins again.
            mine_q <= mine;
            idx    <= 6'd0;
        end else if (state == ST_SCAN) begin
            cnt_mem[idx] <= wr_val;
            idx          <= idx + 6'd1;
        end else begin
            idx <= idx;
        end
    end

    assign rd_cnt  = cnt_mem[rd_addr];
    assign rd_mine = mine_q[rd_addr];

endmodule
